// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one PREP cycle, 32 CALC cycles, one FIX cycle, one DONE pulse.
// Latency start->done is 34 edges for every op; start is ignored while busy, kill aborts PREP/CALC/FIX.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] md_out
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   m_q;
  logic [XLEN-1:0]   hi, lo;
  logic              neg_q;

  logic              a_neg, b_neg, is_mul, res_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     sh;
  logic              borrow;
  logic [XLEN-1:0]   dif;
  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   quo_n, rem_n, fix_res;

  always_comb begin
    a_neg   = a_q[XLEN-1] & (op_q == 3'd1 || op_q == 3'd2 || op_q == 3'd4 || op_q == 3'd6);
    b_neg   = b_q[XLEN-1] & (op_q == 3'd1 || op_q == 3'd4 || op_q == 3'd6);
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    is_mul  = ~op_q[2];
    res_neg = (op_q == 3'd6 || op_q == 3'd7) ? a_neg : (a_neg ^ b_neg);

    // hi:lo is the product accumulator for multiply and remainder:quotient for divide
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
    sh      = {hi, lo[XLEN-1]};
    borrow  = sh < {1'b0, m_q};
    dif     = sh[XLEN-1:0] - m_q;

    prod    = {hi, lo};
    prod_n  = neg_q ? -prod : prod;
    quo_n   = neg_q ? -lo : lo;
    rem_n   = neg_q ? -hi : hi;

    fix_res = rem_n;
    case (op_q)
      3'd0:                fix_res = prod_n[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_n[2*XLEN-1:XLEN];
      // divide by zero yields all ones regardless of sign
      3'd4, 3'd5:          fix_res = (m_q == '0) ? '1 : quo_n;
      default:             fix_res = rem_n;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      neg_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      md_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            op_q  <= md_op;
            a_q   <= operand1;
            b_q   <= operand2;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          // sign decode gets its own cycle so it stays off the iteration path
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            m_q   <= is_mul ? a_mag : b_mag;
            hi    <= '0;
            lo    <= is_mul ? b_mag : a_mag;
            neg_q <= res_neg;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (is_mul) begin
              hi <= add_sum[XLEN:1];
              lo <= {add_sum[0], lo[XLEN-1:1]};
            end else begin
              hi <= borrow ? sh[XLEN-1:0] : dif;
              lo <= {lo[XLEN-2:0], ~borrow};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1))
              state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          if (kill) begin
            state <= IDLE;
          end else begin
            md_out <= fix_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, fixed latency, ignored starts, kill and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  md_op;
  logic [31:0] operand1, operand2;
  logic        busy, done;
  logic [31:0] md_out;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .md_op    (md_op),
    .operand1 (operand1),
    .operand2 (operand2),
    .busy     (busy),
    .done     (done),
    .md_out   (md_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses start across one posedge (edge k); returns at the negedge after edge k.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op    = op;
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    kill     = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    md_op    = 3'($urandom_range(0, 7));
    operand1 = $urandom;
    operand2 = $urandom;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Called 'elapsed' negedges after issue returned; checks done timing at k+33..k+35.
  task automatic finish(input string tag, input logic [31:0] exp, input int elapsed);
    repeat (33 - elapsed) @(negedge clk);
    chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk(tag, md_out, exp);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    finish(tag, exp, 0);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; kill = 1'b0; md_op = '0; operand1 = '0; operand2 = '0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul",     3'd0, 32'd7,        32'd6,        32'h0000002A);
    run_op("mulh",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_op("divu",    3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC);
    run_op("remu",    3'd7, 32'hFFFFFFF9, 32'd2,        32'h00000001);
    run_op("divu_z",  3'd5, 32'd123,      32'd0,        32'hFFFFFFFF);
    run_op("rem_z",   3'd6, 32'd123,      32'd0,        32'd123);
    run_op("div_z_n", 3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    // second start at k+10 with different operands must be ignored
    issue(3'd0, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    md_op = 3'd0; operand1 = 32'd5; operand2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid_ignored_start", {31'd0, busy}, 32'd1);
    finish("ignore_start", 32'd300, 10);

    // kill while counter = 15
    issue(3'd5, 32'd1000, 32'd3);
    repeat (16) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_done", {31'd0, done}, 32'd0);
    chk("kill_md_out", md_out, 32'd300);
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("kill_no_done", 32'(seen_done), 32'd0);
    chk("kill_md_out_hold", md_out, 32'd300);
    run_op("after_kill", 3'd5, 32'd100, 32'd7, 32'd14);

    // kill and start together in IDLE: start ignored
    @(negedge clk);
    md_op = 3'd0; operand1 = 32'd2; operand2 = 32'd2; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill_start_idle_busy", {31'd0, busy}, 32'd1 - 32'd1);
    repeat (40) @(negedge clk);
    chk("kill_start_idle_md_out", md_out, 32'd14);

    // asynchronous reset mid-CALC
    issue(3'd0, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_md_out", md_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
